spi_master: RTL and testbench
=============================

# spi_master

SPI master that serialises one `WIDTH`-bit word on MOSI while capturing `WIDTH` bits from MISO. It supports all four CKP/CPH modes. The block is the device-under-test driven by the SPI test bench, which supplies CLK, RESET, CKP and CPH and observes MOSI, MISO, SCK and CS. Its parallel side is loaded by the system (test words 16'h0015 and 16'h0062).

## Interface
- `WIDTH`, 16: bits per transaction.
- `HALF`, 2: SCK half-period in CLK cycles (≥1).
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `CKP`  in  1  clock polarity; idle SCK level.
- `CPH`  in  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
- `START`  in  1  request a transaction; sampled only in IDLE.
- `TX_DATA`  in  WIDTH  word to send, MSB first; latched when START is accepted.
- `MISO`  in  1  serial data from slave.
- `MOSI`  out  1  serial data to slave.
- `SCK`  out  1  serial clock.
- `CS`  out  1  active-low chip select.
- `RX_DATA`  out  WIDTH  last received word, MSB first.
- `BUSY`  out  1  high from START acceptance until DONE.
- `DONE`  out  1  one-cycle pulse at end of transaction.

## Operation
- Reset values (RESET=0, immediate): CS=1, SCK=0, MOSI=0, RX_DATA=0, BUSY=0, DONE=0, state IDLE, all counters 0.
- **IDLE:**
  - CS=1, SCK registered to CKP every cycle, MOSI=0.
  - START=1 at a rising edge → latch TX_DATA into shift register, latch CKP/CPH, BUSY=1, go to LEAD.
- **LEAD** (HALF cycles):
  - CS=0, SCK = latched CKP.
  - CPH=0: MOSI = TX_DATA[WIDTH-1] from the first LEAD cycle.
  - CPH=1: MOSI=0 until the first SCK edge.
- **XFER:**
  - SCK toggles every HALF cycles, 2·WIDTH edges in total. Odd edges are leading, even edges are trailing.
  - CPH=0: sample MISO on leading edges, shift MOSI to next bit on trailing edges. The final trailing edge does not shift.
  - CPH=1: drive MOSI with next bit (MSB first) on leading edges, sample MISO on trailing edges.
  - Samples shift into the receive register LSB-first-in, so the first bit ends at the MSB.
- **TRAIL** (HALF cycles):
  - SCK = latched CKP, CS=0, MOSI holds last bit.
  - Then CS=1, RX_DATA ← receive register, DONE=1 for one cycle, BUSY=0, back to IDLE.
- Mid-transaction behaviour:
  - CKP/CPH/TX_DATA changes are ignored until the next START acceptance.
  - START while BUSY=1 is ignored, not queued.
  - START=1 in the DONE cycle is ignored; START held high is accepted on the following cycle (back-to-back with ≥1 CS-high cycle).
- Reset mid-transfer aborts immediately: CS=1, RX_DATA=0, no DONE.
- RX_DATA is only written at DONE; it holds between transactions.

## Timing
- START accepted at edge E → CS falls at E (registered output visible after E).
- CS low duration = HALF·(2·WIDTH+2) cycles; defaults give 68 cycles.
- First SCK edge is HALF cycles after CS falls. Edge k (1..2·WIDTH) occurs HALF·k cycles after CS falls.
- CS rises and DONE pulses HALF·(2·WIDTH+2) cycles after E; BUSY falls on the same edge.
- Minimum start-to-start period: HALF·(2·WIDTH+2)+1 cycles.
- MISO is sampled on the CLK edge that produces the sampling SCK edge; slave setup of ≥1 CLK cycle is required.

## Test plan
- Reset with CKP=1: hold RESET=0 for 20 ns → CS=1, SCK=0, MOSI=0, BUSY=0, RX_DATA=0. Release → SCK=1 next edge.
- Mode 0 (CKP=0, CPH=0), TX_DATA=16'h0015, MISO tied to MOSI:
  - MOSI = 0000000000010101 at each rising SCK.
  - CS low 68 cycles.
  - DONE pulse → RX_DATA=16'h0015.
- Mode 3 (CKP=1, CPH=1), TX_DATA=16'h0062, loopback:
  - SCK idles high; bits change on falling SCK, sampled on rising SCK.
  - RX_DATA=16'h0062.
- Modes 1 and 2, TX_DATA=16'h0062, MISO driven by a bench slave returning 16'h0015 → RX_DATA=16'h0015 in both modes, MOSI stream = 16'h0062.
- START pulsed again at SCK edge 10, and CKP toggled mid-transfer → single DONE, waveform unchanged, second START ignored.
- RESET=0 at SCK edge 12 → CS=1 immediately, no DONE, RX_DATA=0. A new transaction after release completes normally.

Source files
------------

// File: rtl/spi_master_if.sv
// Bundle of the SPI master's parallel, configuration and serial signals.
// The master modport is the controller's view; the slave modport is the opposite side.
interface spi_master_if #(
  parameter int WIDTH = 16
);
  logic             ckp;
  logic             cph;
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic             miso;
  logic             mosi;
  logic             sck;
  logic             cs;

  modport master (
    input  ckp, cph, start, tx_data, miso,
    output mosi, sck, cs, rx_data, busy, done
  );

  modport slave (
    output ckp, cph, start, tx_data, miso,
    input  mosi, sck, cs, rx_data, busy, done
  );
endinterface

// File: rtl/spi_master.sv
// Single-word SPI master supporting all four CKP/CPH modes.
// Shifts WIDTH bits out on MOSI (MSB first) while capturing WIDTH bits from MISO.
module spi_master #(
  parameter int WIDTH = 16,
  parameter int HALF  = 2
) (
  input logic         clk,
  input logic         rst_n,
  spi_master_if.master bus
);

  localparam int EDGES = 2 * WIDTH;
  localparam int EW    = $clog2(EDGES + 1);
  localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t           state;
  logic [HW-1:0]    half_cnt;
  logic [EW-1:0]    edge_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             ckp_q;
  logic             cph_q;

  logic             half_wrap;
  logic [EW-1:0]    edge_num;
  logic             leading;
  logic             last_edge;
  logic             xfer_done;
  logic             drive_edge;
  logic             sample_edge;

  // edge_cnt holds completed SCK edges, so edge_num is the edge about to be produced.
  assign half_wrap   = (half_cnt == HW'(HALF - 1));
  assign edge_num    = edge_cnt + 1'b1;
  assign leading     = edge_num[0];
  assign last_edge   = (edge_num == EW'(EDGES));
  assign xfer_done   = (edge_cnt == EW'(EDGES));
  // With CPH=0 the first bit is already on MOSI, so the final trailing edge must not shift.
  assign drive_edge  = cph_q ? leading : (!leading && !last_edge);
  assign sample_edge = cph_q ? !leading : leading;

  // NOTE: every register here is state, so all assignments are non-blocking and all
  // of them (shift registers included) take a defined value on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      half_cnt    <= '0;
      edge_cnt    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      ckp_q       <= 1'b0;
      cph_q       <= 1'b0;
      bus.cs      <= 1'b1;
      bus.sck     <= 1'b0;
      bus.mosi    <= 1'b0;
      bus.rx_data <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.cs   <= 1'b1;
          bus.sck  <= bus.ckp;
          bus.mosi <= 1'b0;
          half_cnt <= '0;
          edge_cnt <= '0;
          if (bus.start) begin
            state    <= LEAD;
            bus.cs   <= 1'b0;
            bus.busy <= 1'b1;
            ckp_q    <= bus.ckp;
            cph_q    <= bus.cph;
            rx_sr    <= '0;
            if (bus.cph) begin
              tx_sr <= bus.tx_data;
            end else begin
              bus.mosi <= bus.tx_data[WIDTH-1];
              tx_sr    <= {bus.tx_data[WIDTH-2:0], 1'b0};
            end
          end
        end

        LEAD, XFER: begin
          if (!half_wrap) begin
            half_cnt <= half_cnt + 1'b1;
          end else begin
            half_cnt <= '0;
            if (state == XFER && xfer_done) begin
              state <= TRAIL;
            end else begin
              state    <= XFER;
              bus.sck  <= ~bus.sck;
              edge_cnt <= edge_num;
              if (drive_edge) begin
                bus.mosi <= tx_sr[WIDTH-1];
                tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
              end
              if (sample_edge) rx_sr <= {rx_sr[WIDTH-2:0], bus.miso};
            end
          end
        end

        TRAIL: begin
          bus.sck <= ckp_q;
          if (!half_wrap) begin
            half_cnt <= half_cnt + 1'b1;
          end else begin
            half_cnt    <= '0;
            state       <= IDLE;
            bus.cs      <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.rx_data <= rx_sr;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expected words, a negedge monitor
// reconstructs the MOSI stream, models the slave, and checks each DONE.
module tb_spi_master;

  localparam int WIDTH  = 16;
  localparam int HALF   = 2;
  localparam int EDGES  = 2 * WIDTH;
  localparam int CS_LOW = HALF * (EDGES + 2);

  typedef struct packed {
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] tx;
    logic             ckp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_master_if #(.WIDTH(WIDTH)) bus ();

  spi_master #(.WIDTH(WIDTH), .HALF(HALF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               checks      = 0;
  int               errors      = 0;
  int               edge_k      = 0;
  int               cs_low_cnt  = 0;
  int               cs_high_cnt = 0;
  int               last_gap    = 0;
  int               done_cnt    = 0;
  logic             loopback    = 1'b1;
  logic             slave_bit   = 1'b0;
  logic             cur_cph     = 1'b0;
  logic             cur_ckp     = 1'b0;
  logic             sck_prev    = 1'b0;
  logic             cs_prev     = 1'b1;
  logic [WIDTH-1:0] slave_word  = '0;
  logic [WIDTH-1:0] slave_sr    = '0;
  logic [WIDTH-1:0] mosi_cap    = '0;

  assign bus.miso = loopback ? bus.mosi : slave_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor and bench slave: everything is observed half a clock after the active edge.
  always @(negedge clk) begin
    if (bus.cs === 1'b0 && cs_prev === 1'b1) begin
      edge_k     = 0;
      cs_low_cnt = 0;
      mosi_cap   = '0;
      last_gap   = cs_high_cnt;
      slave_sr   = slave_word;
      slave_bit  = slave_sr[WIDTH-1];
      check("lead_sck", bus.sck, cur_ckp);
    end
    if (bus.cs === 1'b0) begin
      cs_low_cnt++;
      cs_high_cnt = 0;
    end else begin
      cs_high_cnt++;
    end
    if (bus.cs === 1'b0 && cs_prev === 1'b0 && bus.sck !== sck_prev) begin
      edge_k++;
      if (cur_cph ? (edge_k % 2 == 0) : (edge_k % 2 == 1)) begin
        mosi_cap  = {mosi_cap[WIDTH-2:0], bus.mosi};
        slave_sr  = {slave_sr[WIDTH-2:0], 1'b0};
        slave_bit = slave_sr[WIDTH-1];
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", bus.rx_data, mon_e.rx);
        check("mosi_stream", mosi_cap, mon_e.tx);
        check("cs_low_cycles", cs_low_cnt, CS_LOW);
        check("sck_edges", edge_k, EDGES);
        check("busy_at_done", bus.busy, 0);
        check("sck_after_done", bus.sck, mon_e.ckp);
      end
    end
    sck_prev = bus.sck;
    cs_prev  = bus.cs;
  end

  task automatic wait_done(input int n_before, input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt > n_before) break;
    end
    check({name, "_done"}, done_cnt - n_before, 1);
  endtask

  task automatic wait_edge(input int k, input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (edge_k >= k) break;
    end
    check({name, "_reached"}, edge_k >= k, 1);
  endtask

  task automatic issue(input logic ckp, input logic cph, input logic [WIDTH-1:0] tx,
                       input logic [WIDTH-1:0] sw, input logic loop);
    @(negedge clk);
    bus.ckp     = ckp;
    bus.cph     = cph;
    cur_ckp     = ckp;
    cur_cph     = cph;
    loopback    = loop;
    slave_word  = sw;
    bus.tx_data = tx;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_data = ~tx;
  endtask

  task automatic run_txn(input string name, input logic ckp, input logic cph,
                         input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] sw,
                         input logic loop, input logic [WIDTH-1:0] exp_rx);
    int n;
    n = done_cnt;
    exp_q.push_back('{rx: exp_rx, tx: tx, ckp: ckp});
    issue(ckp, cph, tx, sw, loop);
    wait_done(n, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    bus.ckp     = 1'b1;
    bus.cph     = 1'b0;

    #12;
    check("rst_cs", bus.cs, 1);
    check("rst_sck", bus.sck, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx", bus.rx_data, 0);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1 check("sck_follows_ckp", bus.sck, 1);

    run_txn("mode0", 1'b0, 1'b0, 16'h0015, 16'h0000, 1'b1, 16'h0015);
    run_txn("mode3", 1'b1, 1'b1, 16'h0062, 16'h0000, 1'b1, 16'h0062);
    run_txn("mode1", 1'b0, 1'b1, 16'h0062, 16'h0015, 1'b0, 16'h0015);
    run_txn("mode2", 1'b1, 1'b0, 16'h0062, 16'h0015, 1'b0, 16'h0015);

    repeat (5) @(negedge clk);
    check("rx_hold", bus.rx_data, 16'h0015);
    check("idle_cs", bus.cs, 1);

    // START and CKP/CPH disturbed mid-transfer: waveform and result must be unaffected.
    n = done_cnt;
    exp_q.push_back('{rx: 16'h0015, tx: 16'h0015, ckp: 1'b0});
    issue(1'b0, 1'b0, 16'h0015, 16'h0000, 1'b1);
    wait_edge(10, "edge10");
    @(negedge clk);
    bus.start = 1'b1;
    bus.ckp   = 1'b1;
    bus.cph   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, "ignored_start");
    repeat (10) @(posedge clk);
    check("single_done", done_cnt - n, 1);
    check("no_queued_start", bus.cs, 1);

    // START held high: second word starts one cycle after DONE.
    n = done_cnt;
    exp_q.push_back('{rx: 16'h0062, tx: 16'h0062, ckp: 1'b0});
    exp_q.push_back('{rx: 16'h0062, tx: 16'h0062, ckp: 1'b0});
    @(negedge clk);
    bus.ckp     = 1'b0;
    bus.cph     = 1'b0;
    cur_ckp     = 1'b0;
    cur_cph     = 1'b0;
    loopback    = 1'b1;
    bus.tx_data = 16'h0062;
    bus.start   = 1'b1;
    wait_done(n, "b2b_first");
    #1 check("b2b_restart", bus.cs, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n + 1, "b2b_second");
    check("b2b_gap", last_gap, 1);

    // Reset in the middle of a word aborts it with no DONE.
    n = done_cnt;
    issue(1'b0, 1'b0, 16'h0015, 16'h0000, 1'b1);
    wait_edge(12, "edge12");
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", bus.cs, 1);
    check("abort_rx", bus.rx_data, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_sck", bus.sck, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    check("abort_no_done", done_cnt - n, 0);
    check("abort_rx_hold", bus.rx_data, 0);

    run_txn("after_abort", 1'b1, 1'b1, 16'h0015, 16'h0000, 1'b1, 16'h0015);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
